// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller.
// Holds the FSM state encoding and the MEM/WB control_wb bubble value.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } mem_state_e;

    // control_wb value forced into the MEM/WB latch on a bubble
    localparam logic [1:0] CTRL_WB_NOP = 2'b00;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Timeout counter for outstanding data memory accesses.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear (has priority over i_en)
//   i_en           : count one more cycle without ack
//   o_expire       : count has reached TIMEOUT-1
module mem_timeout_cnt #(
    parameter int unsigned TO_W    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage sequencer for a 5-stage MIPS pipeline with a variable-latency
// data memory (req/ack handshake). Freezes upstream latches while an access
// is outstanding, controls load/bubble of the MEM/WB latch, captures load data,
// guards against a missing ack and counts stall cycles.
// Ports:
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_mem_valid/read/write       : instruction in MEM (read&write = store)
//   o_dmem_req, o_dmem_we        : registered memory request / write qualifier
//   i_dmem_ack, i_dmem_rdata     : memory completion and read data
//   o_mem_rdata                  : captured load data for MEM/WB
//   o_pipe_stall                 : hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   o_mem_wb_en, o_mem_wb_bubble : MEM/WB load enable / control_wb clear
//   i_err_clr, o_bus_err         : clear timeout error / sticky timeout flag
//   o_stall_cnt                  : saturating count of stall cycles
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TO_W    = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    input  logic              i_dmem_ack,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_pipe_stall,
    output logic              o_mem_wb_en,
    output logic              o_mem_wb_bubble,
    input  logic              i_err_clr,
    output logic              o_bus_err,
    output logic [STAT_W-1:0] o_stall_cnt
);

    mem_state_e        r_state;
    mem_state_e        w_state_d;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_bus_err;
    logic [STAT_W-1:0] r_stall_cnt;

    logic w_mem_op;
    logic w_stall;
    logic w_to_clr;
    logic w_to_en;
    logic w_to_expire;

    assign w_mem_op = i_mem_valid & (i_mem_read | i_mem_write);

    mem_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expire (w_to_expire)
    );

    always_comb begin
        w_state_d       = r_state;
        w_stall         = 1'b0;
        o_mem_wb_en     = 1'b1;
        o_mem_wb_bubble = 1'b0;
        // counter only runs inside ACCESS, so it starts at zero on every entry
        w_to_clr        = 1'b1;
        w_to_en         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_stall         = 1'b1;
                    o_mem_wb_bubble = 1'b1;
                    w_state_d       = S_ACCESS;
                end else begin
                    o_mem_wb_bubble = ~i_mem_valid;
                end
            end
            S_ACCESS: begin
                w_stall         = 1'b1;
                o_mem_wb_bubble = 1'b1;
                w_to_clr        = 1'b0;
                // ack wins over a coincident timeout
                if (i_dmem_ack) begin
                    w_state_d = S_DONE;
                end else if (w_to_expire) begin
                    w_state_d = S_ERROR;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            S_ERROR: begin
                w_stall         = 1'b1;
                o_mem_wb_bubble = 1'b1;
                if (i_err_clr) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_mem_rdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= i_mem_write;
                    end
                end
                S_ACCESS: begin
                    if (i_dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        // r_dmem_we still marks the access type here
                        if (!r_dmem_we) begin
                            r_mem_rdata <= i_dmem_rdata;
                        end
                    end else if (w_to_expire) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_bus_err  <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (i_err_clr) begin
                        r_bus_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_pipe_stall = w_stall;
    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_bus_err    = r_bus_err;
    assign o_stall_cnt  = r_stall_cnt;

endmodule
